tile_load_arbiter: RTL and testbench

//  Shares the input-data and weight load buses between N matrix-multiplier tiles.

---
 rtl/tile_arb_pkg.sv | 42 ++++
 rtl/arb_channel.sv | 152 +++++++++++++++
 rtl/tile_load_arbiter.sv | 61 ++++++
 tb/tb_tile_load_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_arb_pkg.sv
// Shared types and the round-robin pick helper for tile_load_arbiter.
// Build option ARB_TIMEOUT_EN (used in arb_channel) enables stalled-burst abort.
package tile_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Upper bound on tiles the pick helper can scan; N_TILES must not exceed it.
    localparam int unsigned MAX_TILES = 32;
    localparam int unsigned IDX_W     = 5;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req at or cyclically after ptr, scanning only the low n bits.
    function automatic pick_t rr_pick(input logic [MAX_TILES-1:0] req,
                                      input logic [IDX_W-1:0]     ptr,
                                      input int unsigned          n);
        pick_t       r;
        int unsigned j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int unsigned k = 0; k < MAX_TILES; k++) begin
            if (k < n && !r.found) begin
                j = 32'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (req[j[IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_channel.sv
// One load-bus channel: round-robin pick, registered one-hot grant, burst beat counter.
// With ARB_TIMEOUT_EN defined, a stall counter aborts bursts stuck without valid data.
module arb_channel
    import tile_arb_pkg::*;
#(
    parameter int unsigned N_TILES   = 4,
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_TILES-1:0]         req_i,
    input  logic                       valid_i,
    output logic [N_TILES-1:0]         grant_o,
    output logic [$clog2(N_TILES)-1:0] owner_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int unsigned CW   = $clog2(N_TILES);
    localparam int unsigned CNTW = $clog2(BURST_LEN) + 1;

    arb_state_e          state_q, state_d;
    logic [N_TILES-1:0]  grant_q, grant_d;
    logic [CW-1:0]       owner_q, owner_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       owner_next;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                last_beat;
    logic                owner_gone;
    pick_t               pick;
    logic [CW-1:0]       pick_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_q, stall_d;
    logic          err_q, err_d;
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT;
`endif

    logic [IDX_W-CW-1+1:0] pick_unused;

    always_comb begin
        pick        = rr_pick(MAX_TILES'(req_i), IDX_W'(ptr_q), N_TILES);
        pick_idx    = CW'(pick.idx);
        pick_unused = (IDX_W - CW + 1)'(pick.idx);
        owner_next  = (owner_q == CW'(N_TILES - 1)) ? '0 : owner_q + 1'b1;
        last_beat   = valid_i && (cnt_q == CNTW'(BURST_LEN - 1));
        owner_gone  = !req_i[owner_q];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        stall_d = stall_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    state_d           = ST_BURST;
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    cnt_d             = '0;
`ifdef ARB_TIMEOUT_EN
                    stall_d           = '0;
`endif
                end
            end
            ST_BURST: begin
                // Completion wins over a same-cycle request drop: the last word still lands.
                if (last_beat) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    done_d  = 1'b1;
                    ptr_d   = owner_next;
                    cnt_d   = '0;
                end else if (owner_gone) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_next;
                    cnt_d   = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (!valid_i && (stall_q == SW'(TIMEOUT - 1))) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    err_d   = 1'b1;
                    ptr_d   = owner_next;
                    cnt_d   = '0;
                end
`endif
                else begin
                    if (valid_i) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef ARB_TIMEOUT_EN
                    stall_d = valid_i ? '0 : stall_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            stall_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef ARB_TIMEOUT_EN
            stall_q <= stall_d;
            err_q   <= err_d;
`endif
        end
    end

    assign grant_o = grant_q;
    assign owner_o = owner_q;
    assign done_o  = done_q;
`ifdef ARB_TIMEOUT_EN
    assign err_o   = err_q;
`else
    assign err_o   = 1'b0;
`endif

endmodule

// File: rtl/tile_load_arbiter.sv
// Grants the input-data and weight load buses to N tiles, one BURST_LEN burst at a time.
// Define ARB_TIMEOUT_EN to abort bursts that stall for TIMEOUT cycles (timeout_err pulse).
module tile_load_arbiter
    import tile_arb_pkg::*;
#(
    parameter int unsigned N_TILES   = 4,
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_TILES-1:0]         req_in,
    input  logic [N_TILES-1:0]         req_w,
    input  logic                       valid_in,
    input  logic                       valid_w,
    output logic [N_TILES-1:0]         grant_in,
    output logic [N_TILES-1:0]         grant_w,
    output logic [$clog2(N_TILES)-1:0] owner_in,
    output logic [$clog2(N_TILES)-1:0] owner_w,
    output logic                       done_in,
    output logic                       done_w,
    output logic                       timeout_err
);

    logic err_in;
    logic err_w;

    // The two channels are fully independent; the same tile may own both.
    arb_channel #(
        .N_TILES   (N_TILES),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_ch_in (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_in),
        .valid_i (valid_in),
        .grant_o (grant_in),
        .owner_o (owner_in),
        .done_o  (done_in),
        .err_o   (err_in)
    );

    arb_channel #(
        .N_TILES   (N_TILES),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_ch_w (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_w),
        .valid_i (valid_w),
        .grant_o (grant_w),
        .owner_o (owner_w),
        .done_o  (done_w),
        .err_o   (err_w)
    );

    assign timeout_err = err_in | err_w;

endmodule

// File: tb/tb_tile_load_arbiter.sv
// Bench for tile_load_arbiter: directed scenarios plus randomized traffic against a burst-level model.
module tb_tile_load_arbiter;

    localparam int N  = 4;
    localparam int BL = 32;
    localparam int TO = 64;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in, req_w;
    logic       valid_in, valid_w;
    logic [3:0] grant_in, grant_w;
    logic [1:0] owner_in, owner_w;
    logic       done_in, done_w, timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per channel (0 = IN, 1 = W); m_own = -1 means no burst in progress.
    int m_own[2], m_last[2], m_beats[2], m_stall[2], m_ptr[2];
    bit m_done[2];
    bit m_err;

    tile_load_arbiter #(.N_TILES(N), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .req_w(req_w),
        .valid_in(valid_in), .valid_w(valid_w),
        .grant_in(grant_in), .grant_w(grant_w),
        .owner_in(owner_in), .owner_w(owner_w),
        .done_in(done_in), .done_w(done_w), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] exp_grant(input int c);
        return (m_own[c] < 0) ? 4'b0000 : (4'b0001 << m_own[c]);
    endfunction

    task automatic model_step();
        logic [3:0] rq;
        bit vl;
        bit e;
        m_err = 1'b0;
        for (int c = 0; c < 2; c++) begin
            rq = (c == 0) ? req_in : req_w;
            vl = (c == 0) ? valid_in : valid_w;
            m_done[c] = 1'b0;
            e = 1'b0;
            if (rst) begin
                m_own[c] = -1; m_last[c] = 0; m_ptr[c] = 0; m_beats[c] = 0; m_stall[c] = 0;
            end else if (m_own[c] < 0) begin
                for (int k = 0; k < N; k++) begin
                    int t;
                    t = (m_ptr[c] + k) % N;
                    if (rq[2'(t)]) begin
                        m_own[c] = t; m_last[c] = t; m_beats[c] = 0; m_stall[c] = 0;
                        break;
                    end
                end
            end else if (vl && (m_beats[c] + 1 == BL)) begin
                m_done[c] = 1'b1;
                m_ptr[c] = (m_own[c] + 1) % N;
                m_own[c] = -1;
            end else if (!rq[2'(m_own[c])]) begin
                m_ptr[c] = (m_own[c] + 1) % N;
                m_own[c] = -1;
            end else if (vl) begin
                m_beats[c]++;
                m_stall[c] = 0;
            end else begin
                m_stall[c]++;
                if (TO_EN && m_stall[c] == TO) begin
                    e = 1'b1;
                    m_ptr[c] = (m_own[c] + 1) % N;
                    m_own[c] = -1;
                end
            end
            m_err = m_err | e;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_in = '0; req_w = '0; valid_in = 1'b0; valid_w = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        rst = 1'b1; req_in = 4'hF; req_w = 4'hF; valid_in = 1'b1; valid_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {grant_in, grant_w, owner_in, owner_w, done_in, done_w, timeout_err};
            n_cmp++;
            if (got !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs cycle=%0d got=%h want=0", i, got);
            end
        end
        rst = 1'b0; req_in = '0; req_w = '0; valid_in = 1'b0; valid_w = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_in = 4'b0100;
        tick();
        n_cmp++;
        if (grant_in !== 4'b0100 || owner_in !== 2'd2) begin
            n_bad++;
            $display("FAIL single_grant got=%b/%0d want=0100/2", grant_in, owner_in);
        end
        valid_in = 1'b1;
        repeat (31) tick();
        n_cmp++;
        if (grant_in !== 4'b0100 || done_in !== 1'b0) begin
            n_bad++;
            $display("FAIL single_hold got=%b done=%b want=0100 done=0", grant_in, done_in);
        end
        tick();
        n_cmp++;
        if (grant_in !== 4'b0000 || done_in !== 1'b1) begin
            n_bad++;
            $display("FAIL single_done got=%b done=%b want=0000 done=1", grant_in, done_in);
        end
        valid_in = 1'b0; req_in = '0;
        tick();
        n_cmp++;
        if (done_in !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done_pulse got=%b want=0", done_in);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        do_reset();
        req_in = 4'b1111; valid_in = 1'b1;
        for (int g = 0; g < 5; g++) begin
            want = 4'b0001 << (g % 4);
            tick();
            n_cmp++;
            if (grant_in !== want || owner_in !== 2'(g % 4)) begin
                n_bad++;
                $display("FAIL rr_grant idx=%0d got=%b/%0d want=%b/%0d", g, grant_in, owner_in, want, g % 4);
            end
            repeat (31) tick();
            n_cmp++;
            if (grant_in !== want) begin
                n_bad++;
                $display("FAIL rr_hold idx=%0d got=%b want=%b", g, grant_in, want);
            end
            tick();
            n_cmp++;
            if (grant_in !== 4'b0000 || done_in !== 1'b1) begin
                n_bad++;
                $display("FAIL rr_gap idx=%0d got=%b done=%b want=0000 done=1", g, grant_in, done_in);
            end
        end
        req_in = '0; valid_in = 1'b0;
    endtask

    task automatic test_dual_channel();
        int t_in, t_w;
        do_reset();
        req_in = 4'b0010; req_w = 4'b0010;
        tick();
        n_cmp++;
        if (grant_in !== 4'b0010 || grant_w !== 4'b0010) begin
            n_bad++;
            $display("FAIL dual_grant got=%b/%b want=0010/0010", grant_in, grant_w);
        end
        t_in = -1; t_w = -1;
        for (int i = 0; i < 100 && t_w < 0; i++) begin
            valid_in = 1'b1;
            valid_w  = (i % 2) == 1;
            tick();
            if (done_in && t_in < 0) t_in = i + 1;
            if (done_w && t_w < 0) t_w = i + 1;
        end
        n_cmp++;
        if (t_in != 32 || t_w != 64) begin
            n_bad++;
            $display("FAIL dual_done_times got=%0d/%0d want=32/64", t_in, t_w);
        end
        req_in = '0; req_w = '0; valid_in = 1'b0; valid_w = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        bit seen;
        do_reset();
        req_in = 4'b0001;
        tick();
        n = 0; seen = 1'b0;
        while (n < 100 && !seen) begin
            valid_in = !(n >= 10 && n < 15);
            tick();
            n++;
            if (n == 14) begin
                n_cmp++;
                if (grant_in !== 4'b0001) begin
                    n_bad++;
                    $display("FAIL stall_hold got=%b want=0001", grant_in);
                end
            end
            seen = done_in;
        end
        n_cmp++;
        if (!seen || n != 37) begin
            n_bad++;
            $display("FAIL stall_done_latency got=%0d want=37", n);
        end
        req_in = '0; valid_in = 1'b0;
    endtask

    task automatic test_drop();
        do_reset();
        req_in = 4'b0110;
        tick();
        n_cmp++;
        if (grant_in !== 4'b0010 || owner_in !== 2'd1) begin
            n_bad++;
            $display("FAIL drop_first_grant got=%b/%0d want=0010/1", grant_in, owner_in);
        end
        valid_in = 1'b1;
        repeat (7) tick();
        req_in = 4'b0100;
        tick();
        n_cmp++;
        if (grant_in !== 4'b0000 || done_in !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_release got=%b done=%b want=0000 done=0", grant_in, done_in);
        end
        tick();
        n_cmp++;
        if (grant_in !== 4'b0100 || owner_in !== 2'd2) begin
            n_bad++;
            $display("FAIL drop_next_owner got=%b/%0d want=0100/2", grant_in, owner_in);
        end
        req_in = '0; valid_in = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [16:0] got;
        do_reset();
        req_in = 4'b1111; req_w = 4'b1000; valid_in = 1'b1; valid_w = 1'b1;
        tick();
        repeat (32) tick();
        tick();
        n_cmp++;
        if (grant_in !== 4'b0010) begin
            n_bad++;
            $display("FAIL midrst_second_grant got=%b want=0010", grant_in);
        end
        repeat (5) tick();
        rst = 1'b1;
        tick();
        got = {grant_in, grant_w, owner_in, owner_w, done_in, done_w, timeout_err};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs got=%h want=0", got);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (grant_in !== 4'b0001 || grant_w !== 4'b1000) begin
            n_bad++;
            $display("FAIL midrst_restart got=%b/%b want=0001/1000", grant_in, grant_w);
        end
        req_in = '0; req_w = '0; valid_in = 1'b0; valid_w = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req_w = 4'b0001; valid_w = 1'b0;
        tick();
        repeat (63) tick();
        n_cmp++;
        if (grant_w !== 4'b0001 || timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early got=%b err=%b want=0001 err=0", grant_w, timeout_err);
        end
        tick();
        n_cmp++;
        if (grant_w !== 4'b0000 || timeout_err !== 1'b1 || done_w !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_abort got=%b err=%b done=%b want=0000 err=1 done=0", grant_w, timeout_err, done_w);
        end
        req_w = '0;
    endtask
`endif

    task automatic test_random();
        logic [16:0] got, want;
        int shown;
        do_reset();
        shown = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) req_in = 4'($urandom);
            if ($urandom_range(15) == 0) req_w  = 4'($urandom);
            valid_in = ($urandom_range(3) != 0);
            if (i >= 1000 && i < 1400) valid_w = ($urandom_range(39) == 0);
            else                       valid_w = ($urandom_range(3) != 0);
            rst = ($urandom_range(499) == 0);
            tick();
            want = {exp_grant(0), exp_grant(1), 2'(m_last[0]), 2'(m_last[1]),
                    m_done[0], m_done[1], m_err};
            got  = {grant_in, grant_w, owner_in, owner_w, done_in, done_w, timeout_err};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_cycle cyc=%0d got=%h want=%h", i, got, want);
                end
            end
        end
        rst = 1'b0; req_in = '0; req_w = '0; valid_in = 1'b0; valid_w = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_in = '0; req_w = '0; valid_in = 1'b0; valid_w = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_own[c] = -1; m_last[c] = 0; m_beats[c] = 0; m_stall[c] = 0; m_ptr[c] = 0; m_done[c] = 1'b0;
        end
        m_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_dual_channel();
        test_stall();
        test_drop();
        test_reset_mid_burst();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
